stage_if: RTL and testbench
===========================

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset; one clock domain only.
REQ-003 stall  in  1  pipeline freeze from controller: IF/ID register holds while high.
REQ-004 br  in  1  branch-taken flag from ID for the instruction currently held in IF/ID.
REQ-005 br_addr  in  32  branch/jump target from ID.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  32  fetch word address; held stable while imem_req=1 and no ack.
REQ-008 imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 pc  out  32  address of the instruction in IF/ID, to ID.
REQ-011 inst  out  32  instruction in IF/ID, to ID; 0 (NOP) when invalid.
REQ-012 inst_valid  out  1  IF/ID holds a fetched instruction.
REQ-013 cur_in_delay_slot  out  1  IF/ID instruction is a branch delay slot; feeds ID cur_in_delay_slot_i.
REQ-014 fetch_err  out  1  misaligned fetch target detected (tied 0 when feature absent).

Function
REQ-015 State machine SHALL have states REQ, HOLD and ERR; reset state REQ.
REQ-016 In REQ, imem_req=1 and imem_addr=fetch_pc; in HOLD and ERR, imem_req=0.
REQ-017 "Consume" SHALL mean loading IF/ID: pc<=word address, inst<=word, inst_valid<=1.
REQ-018 REQ with imem_ack=1 and stall=0: consume imem_rdata that edge; stay in REQ with the next fetch_pc (back-to-back, zero bubble).
REQ-019 REQ with imem_ack=1 and stall=1: capture word and address into a one-entry skid buffer; go to HOLD.
REQ-020 HOLD with stall=0: consume from skid buffer; go to REQ. HOLD with stall=1: no change.
REQ-021 br SHALL be sampled only when inst_valid=1 and stall=0 ("live branch").
REQ-022 A live branch not coinciding with a consume edge SHALL set br_pending and latch br_target<=br_addr; repeated sampling of the same branch is idempotent.
REQ-023 At every consume edge: eff_br = live branch OR br_pending; eff_target = br_pending ? br_target : br_addr.
REQ-024 At a consume edge, fetch_pc <= eff_br ? eff_target : fetch_pc+4 (mod 2^32, wraps at 0xFFFFFFFC).
REQ-025 At a consume edge, cur_in_delay_slot <= eff_br and br_pending <= 0.
REQ-026 The word fetched after a branch (address branch_pc+4) is therefore the delay slot and executes; redirection applies to the following fetch.
REQ-027 Fetch latency: ack in the first request cycle gives inst_valid the next cycle; each wait cycle adds one.
REQ-028 stall held with no outstanding ack SHALL keep imem_req asserted; the request is not abandoned.

Reset
REQ-029 On rst_n=0, immediately: fetch_pc=0x00000000, pc=0, inst=0, inst_valid=0, cur_in_delay_slot=0, br_pending=0, skid buffer empty, fetch_err=0, imem_req=0.
REQ-030 Reset mid-fetch SHALL drop the outstanding request; the first request after release is to 0x00000000.

Configuration
REQ-031 Macro IF_ALIGN_CHECK_EN: when defined, an eff_target with bits[1:0]!=0 at a consume edge SHALL move to ERR, set fetch_err=1 (sticky until reset), and issue no further requests; the delay-slot word is still consumed.
REQ-032 Without IF_ALIGN_CHECK_EN: imem_addr={fetch_pc[31:2],2'b00}, fetch_err constant 0, and ERR is unreachable.

Verification
REQ-033 Zero-wait memory, no branches: sequence addresses 0x0,0x4,0x8; inst_valid rises 1 cycle after reset release; pc increments by 4 each cycle.
REQ-034 Branch: word at 0x8 with br=1, br_addr=0x100; pc sequence 0x8,0xC(cur_in_delay_slot=1),0x100(cur_in_delay_slot=0).
REQ-035 Branch with 3-cycle ack latency on the delay-slot fetch: br_pending set; next imem_addr after the 0xC consume = 0x100.
REQ-036 Ack at 0x10 while stall=1 for 4 cycles: enter HOLD, imem_req=0, IF/ID unchanged; on stall release pc=0x10 next cycle, then request 0x14.
REQ-037 Reset asserted during a wait cycle at 0x20: outputs zero immediately; after release first imem_addr=0x0.
REQ-038 With IF_ALIGN_CHECK_EN: br_addr=0x102 -> delay slot consumed, fetch_err=1, imem_req=0 thereafter; without the macro, the next imem_addr=0x100.

Source files
------------

// File: rtl/stage_if.sv
// stage_if: instruction fetch stage with IF/ID register, one-entry skid buffer and delayed-branch redirect.
// Define IF_ALIGN_CHECK_EN to trap misaligned branch targets (ERR state, sticky fetch_err).
module stage_if (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        cur_in_delay_slot,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_ERR} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_ds;
    logic        r_br_pending;
    logic [31:0] r_br_target;
    logic [31:0] r_skid_addr;
    logic [31:0] r_skid_data;

    logic        w_live_br;
    logic        w_eff_br;
    logic [31:0] w_eff_target;
    logic        w_misalign;
    logic        w_consume;
    logic [31:0] w_word;
    logic [31:0] w_word_addr;
    logic [31:0] w_fetch_word_addr;

    // ID only drives br meaningfully for a valid, unfrozen IF/ID entry
    assign w_live_br         = r_inst_valid & ~stall & br;
    assign w_eff_br          = w_live_br | r_br_pending;
    assign w_eff_target      = r_br_pending ? r_br_target : br_addr;
    assign w_fetch_word_addr = {r_fetch_pc[31:2], 2'b00};

`ifdef IF_ALIGN_CHECK_EN
    assign w_misalign = w_eff_br & (w_eff_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_REQ;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        imem_req    = 1'b0;
        w_consume   = 1'b0;
        w_word      = imem_rdata;
        w_word_addr = w_fetch_word_addr;
        case (r_state)
            S_REQ: begin
                // gated so the request drops the instant reset is asserted
                imem_req = rst_n;
                if (imem_ack) begin
                    if (stall) w_next    = S_HOLD;
                    else       w_consume = 1'b1;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_consume   = 1'b1;
                    w_word      = r_skid_data;
                    w_word_addr = r_skid_addr;
                    w_next      = S_REQ;
                end
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_REQ;
        endcase
        if (w_consume && w_misalign) w_next = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= 32'h0;
            r_pc         <= 32'h0;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_ds         <= 1'b0;
            r_br_pending <= 1'b0;
            r_br_target  <= 32'h0;
            r_skid_addr  <= 32'h0;
            r_skid_data  <= 32'h0;
        end else begin
            if (r_state == S_REQ && imem_ack && stall) begin
                r_skid_addr <= w_fetch_word_addr;
                r_skid_data <= imem_rdata;
            end
            if (w_consume) begin
                r_pc         <= w_word_addr;
                r_inst       <= w_word;
                r_inst_valid <= 1'b1;
                r_ds         <= w_eff_br;
                r_br_pending <= 1'b0;
                r_fetch_pc   <= w_eff_br ? w_eff_target : r_fetch_pc + 32'd4;
            end else if (w_live_br && !r_br_pending) begin
                // remember the redirect until the delay-slot word lands
                r_br_pending <= 1'b1;
                r_br_target  <= br_addr;
            end
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic r_fetch_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_fetch_err <= 1'b0;
        else if (w_consume && w_misalign) r_fetch_err <= 1'b1;
    end

    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_addr         = w_fetch_word_addr;
    assign pc                = r_pc;
    assign inst              = r_inst;
    assign inst_valid        = r_inst_valid;
    assign cur_in_delay_slot = r_ds;

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed scenarios plus a randomized run against a queue-based delayed-branch fetch model.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        cur_in_delay_slot;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    int lat_mode = 0;
    int lat_map [logic [31:0]];
    int wcnt = 0;
    bit busy = 1'b0;

    logic [31:0] maddr [0:4095];
    logic [31:0] mtgt  [0:4095];
    bit          mbr   [0:4095];

    stage_if dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .br                (br),
        .br_addr           (br_addr),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .pc                (pc),
        .inst              (inst),
        .inst_valid        (inst_valid),
        .cur_in_delay_slot (cur_in_delay_slot),
        .fetch_err         (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: per-request latency (map entry, fixed, or random 0..3 wait cycles)
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                if (lat_map.exists(imem_addr)) wcnt = lat_map[imem_addr];
                else if (lat_mode < 0)         wcnt = $urandom_range(0, 3);
                else                           wcnt = lat_mode;
            end
            if (wcnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wcnt--;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; br = 1'b0; br_addr = 32'h0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({imem_req, inst_valid, cur_in_delay_slot, fetch_err} !== 4'b0)
            begin failures++; $display("FAIL reset_flags got=%b want=0000", {imem_req, inst_valid, cur_in_delay_slot, fetch_err}); end
        checks++;
        if (pc !== 32'h0 || inst !== 32'h0)
            begin failures++; $display("FAIL reset_data pc=%h inst=%h want 0/0", pc, inst); end
    endtask

    task automatic test_seq();
        lat_map.delete(); lat_mode = 0; do_reset();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
            begin failures++; $display("FAIL seq_first_req req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, inst_valid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (inst_valid !== 1'b1 || pc !== 32'(4 * i) || inst !== memf(32'(4 * i)))
                begin failures++; $display("FAIL seq_ifid i=%0d v=%b pc=%h inst=%h want pc=%h", i, inst_valid, pc, inst, 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        lat_map.delete(); lat_mode = 0; do_reset();
        repeat (3) @(posedge clk); #1;
        checks++;
        if (pc !== 32'h8) begin failures++; $display("FAIL br_pre pc=%h want 8", pc); end
        br = 1'b1; br_addr = 32'h100;
        @(posedge clk); #1;
        br = 1'b0; br_addr = 32'h0;
        checks++;
        if (pc !== 32'hC || cur_in_delay_slot !== 1'b1 || imem_addr !== 32'h100)
            begin failures++; $display("FAIL br_slot pc=%h ds=%b addr=%h want C/1/100", pc, cur_in_delay_slot, imem_addr); end
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h100 || cur_in_delay_slot !== 1'b0 || inst !== memf(32'h100))
            begin failures++; $display("FAIL br_target pc=%h ds=%b inst=%h want 100/0", pc, cur_in_delay_slot, inst); end
    endtask

    task automatic test_branch_latency();
        lat_map.delete(); lat_map[32'hC] = 3; lat_mode = 0; do_reset();
        repeat (3) @(posedge clk); #1;
        br = 1'b1; br_addr = 32'h100;
        @(posedge clk); #1;
        // ID moves on; the latched target must be used, not the bus
        br = 1'b0; br_addr = 32'hDEAD_BEE0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc !== 32'h8)
            begin failures++; $display("FAIL brl_wait req=%b addr=%h pc=%h want 1/C/8", imem_req, imem_addr, pc); end
        for (int i = 0; i < 8 && !(inst_valid === 1'b1 && pc === 32'hC); i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pc !== 32'hC || cur_in_delay_slot !== 1'b1 || imem_addr !== 32'h100)
            begin failures++; $display("FAIL brl_slot pc=%h ds=%b addr=%h want C/1/100", pc, cur_in_delay_slot, imem_addr); end
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h100 || cur_in_delay_slot !== 1'b0)
            begin failures++; $display("FAIL brl_target pc=%h ds=%b want 100/0", pc, cur_in_delay_slot); end
        br_addr = 32'h0;
    endtask

    task automatic test_stall_hold();
        lat_map.delete(); lat_mode = 0; do_reset();
        repeat (4) @(posedge clk); #1;
        checks++;
        if (pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h10)
            begin failures++; $display("FAIL hold_pre pc=%h req=%b addr=%h want C/1/10", pc, imem_req, imem_addr); end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (imem_req !== 1'b0 || pc !== 32'hC || inst !== memf(32'hC) || inst_valid !== 1'b1)
                begin failures++; $display("FAIL hold_frozen i=%0d req=%b pc=%h inst=%h want 0/C", i, imem_req, pc, inst); end
        end
        stall = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h10 || inst !== memf(32'h10) || imem_req !== 1'b1 || imem_addr !== 32'h14)
            begin failures++; $display("FAIL hold_release pc=%h inst=%h req=%b addr=%h want 10/-/1/14", pc, inst, imem_req, imem_addr); end
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h14) begin failures++; $display("FAIL hold_next pc=%h want 14", pc); end
    endtask

    task automatic test_reset_mid();
        lat_map.delete(); lat_map[32'h20] = 5; lat_mode = 0; do_reset();
        repeat (9) @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20 || pc !== 32'h1C)
            begin failures++; $display("FAIL rstm_wait req=%b addr=%h pc=%h want 1/20/1C", imem_req, imem_addr, pc); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, inst_valid, cur_in_delay_slot, fetch_err} !== 4'b0 || pc !== 32'h0 || inst !== 32'h0)
            begin failures++; $display("FAIL rstm_async flags=%b pc=%h inst=%h want 0", {imem_req, inst_valid, cur_in_delay_slot, fetch_err}, pc, inst); end
        lat_map.delete();
        do_reset();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin failures++; $display("FAIL rstm_restart req=%b addr=%h want 1/0", imem_req, imem_addr); end
        @(posedge clk); #1;
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h0)
            begin failures++; $display("FAIL rstm_first v=%b pc=%h want 1/0", inst_valid, pc); end
    endtask

    task automatic test_misalign();
        lat_map.delete(); lat_mode = 0; do_reset();
        repeat (3) @(posedge clk); #1;
        br = 1'b1; br_addr = 32'h102;
        @(posedge clk); #1;
        br = 1'b0; br_addr = 32'h0;
        checks++;
        if (pc !== 32'hC || cur_in_delay_slot !== 1'b1 || inst_valid !== 1'b1)
            begin failures++; $display("FAIL mis_slot pc=%h ds=%b want C/1", pc, cur_in_delay_slot); end
`ifdef IF_ALIGN_CHECK_EN
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0)
            begin failures++; $display("FAIL mis_err err=%b req=%b want 1/0", fetch_err, imem_req); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'hC)
            begin failures++; $display("FAIL mis_sticky err=%b req=%b pc=%h want 1/0/C", fetch_err, imem_req, pc); end
`else
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
            begin failures++; $display("FAIL mis_noerr err=%b req=%b addr=%h want 0/1/100", fetch_err, imem_req, imem_addr); end
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h100 || inst !== memf(32'h100))
            begin failures++; $display("FAIL mis_target pc=%h inst=%h want 100", pc, inst); end
`endif
    endtask

    // Model: fetch n+2 goes to instr n's target if instr n branched, else sequential;
    // delivered words queue until a non-stalled edge moves them into IF/ID.
    task automatic test_random(input int ncyc);
        int          q[$];
        int          n_fetch;
        int          cur;
        logic        req_s, ack_s;
        logic [31:0] addr_s;
        bit          stall_s, exp_ds;
        lat_map.delete(); lat_mode = -1; do_reset();
        maddr[0] = 32'h0; n_fetch = 0; cur = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 3) == 0);
            if (cur >= 0) begin
                br      = mbr[cur];
                br_addr = mbr[cur] ? mtgt[cur] : $urandom;
            end else begin
                br      = 1'($urandom_range(0, 1));
                br_addr = $urandom;
            end
            #1;
            req_s = imem_req; ack_s = imem_ack; addr_s = imem_addr; stall_s = stall;
            checks++;
            if (req_s !== (q.size() == 0))
                begin failures++; $display("FAIL rnd_req cyc=%0d req=%b want %b", c, req_s, q.size() == 0); end
            if (req_s === 1'b1 && q.size() == 0) begin
                checks++;
                if (addr_s !== maddr[n_fetch])
                    begin failures++; $display("FAIL rnd_addr cyc=%0d addr=%h want %h", c, addr_s, maddr[n_fetch]); end
            end
            @(posedge clk); #1;
            if (ack_s === 1'b1 && n_fetch < 4095) begin
                q.push_back(n_fetch);
                n_fetch++;
            end
            if (!stall_s && q.size() > 0) begin
                cur      = q.pop_front();
                mbr[cur] = ($urandom_range(0, 3) == 0);
                mtgt[cur] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
                maddr[cur + 1] = (cur >= 1 && mbr[cur - 1]) ? mtgt[cur - 1] : maddr[cur] + 32'd4;
            end
            checks++;
            if (cur < 0) begin
                if (inst_valid !== 1'b0 || inst !== 32'h0)
                    begin failures++; $display("FAIL rnd_empty cyc=%0d v=%b inst=%h want 0/0", c, inst_valid, inst); end
            end else begin
                exp_ds = (cur >= 1) && mbr[cur - 1];
                if (inst_valid !== 1'b1 || pc !== maddr[cur] || inst !== memf(maddr[cur]) || cur_in_delay_slot !== exp_ds)
                    begin failures++; $display("FAIL rnd_ifid cyc=%0d v=%b pc=%h want %h inst=%h want %h ds=%b want %b",
                        c, inst_valid, pc, maddr[cur], inst, memf(maddr[cur]), cur_in_delay_slot, exp_ds); end
            end
        end
        br = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_branch_latency();
        test_stall_hold();
        test_reset_mid();
        test_misalign();
        test_random(1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
